// File: rtl/race_ctrl_if.sv
// rtl/race_ctrl_if.sv - renderer-side signal bundle between the road renderer and race_ctrl
// master drives pixel/key inputs; slave is the game-state controller.
interface race_ctrl_if;
  logic        refresh_tick;
  logic        video_on;
  logic        car_on;
  logic        road_on;
  logic        finish_line;
  logic        start_key;
  logic        pause_key;
  logic        pause;
  logic        road_reset;
  logic [1:0]  lives;
  logic [15:0] frame_time;
  logic [2:0]  state;
  logic        crash_flash;

  modport master (
    output refresh_tick, video_on, car_on, road_on, finish_line, start_key, pause_key,
    input  pause, road_reset, lives, frame_time, state, crash_flash
  );

  modport slave (
    input  refresh_tick, video_on, car_on, road_on, finish_line, start_key, pause_key,
    output pause, road_reset, lives, frame_time, state, crash_flash
  );
endinterface

// File: rtl/race_ctrl.sv
// rtl/race_ctrl.sv - game-state controller: crash/finish detection per frame, lives, frame timer
// Decisions are taken on refresh_tick from flags gathered over the previous frame.
module race_ctrl #(
  parameter int LIVES        = 3,
  parameter int CRASH_FRAMES = 60
) (
  input logic        clk,
  input logic        reset,
  race_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_PAUSED = 3'd2,
    S_CRASH  = 3'd3,
    S_WIN    = 3'd4,
    S_OVER   = 3'd5
  } state_e;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] CRASH_INIT = 8'(CRASH_FRAMES);

  state_e      state_q, state_d;
  logic        hit_q, hit_d, fin_q, fin_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] ft_q, ft_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pause_q, pause_d;
  logic        rr_q, rr_d;
  logic        flash_q, flash_d;
  logic        hit_ev, fin_ev;

  assign hit_ev = bus.video_on & bus.car_on & ~bus.road_on;
  assign fin_ev = bus.video_on & bus.car_on & bus.finish_line;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    ft_d    = ft_q;
    cnt_d   = cnt_q;
    rr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_key) begin
          state_d = S_PLAY;
          ft_d    = 16'd0;
          lives_d = LIVES_INIT;
          rr_d    = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.refresh_tick && hit_q) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = S_CRASH;
            cnt_d   = CRASH_INIT;
          end
        end else if (bus.refresh_tick && fin_q) begin
          state_d = S_WIN;
        end else if (bus.pause_key) begin
          state_d = S_PAUSED;
        end else if (bus.refresh_tick && ft_q != 16'hFFFF) begin
          ft_d = ft_q + 16'd1;
        end
      end
      S_PAUSED: begin
        if (bus.pause_key) state_d = S_PLAY;
      end
      S_CRASH: begin
        if (bus.refresh_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = 8'd0;
            state_d = S_PLAY;
            rr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_WIN, S_OVER: begin
        if (bus.start_key) begin
          state_d = S_IDLE;
          rr_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags only accumulate while play continues; any entry to PLAY starts them clean.
    if (state_q == S_PLAY && state_d == S_PLAY) begin
      hit_d = bus.refresh_tick ? hit_ev : (hit_q | hit_ev);
      fin_d = bus.refresh_tick ? fin_ev : (fin_q | fin_ev);
    end else begin
      hit_d = 1'b0;
      fin_d = 1'b0;
    end

    pause_d = (state_d != S_PLAY);
    flash_d = (state_d == S_CRASH) & cnt_d[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hit_q   <= 1'b0;
      fin_q   <= 1'b0;
      lives_q <= LIVES_INIT;
      ft_q    <= 16'd0;
      cnt_q   <= 8'd0;
      pause_q <= 1'b1;
      rr_q    <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      fin_q   <= fin_d;
      lives_q <= lives_d;
      ft_q    <= ft_d;
      cnt_q   <= cnt_d;
      pause_q <= pause_d;
      rr_q    <= rr_d;
      flash_q <= flash_d;
    end
  end

  assign bus.pause       = pause_q;
  assign bus.road_reset  = rr_q;
  assign bus.lives       = lives_q;
  assign bus.frame_time  = ft_q;
  assign bus.state       = state_q;
  assign bus.crash_flash = flash_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb/tb_race_ctrl.sv - scoreboard bench for race_ctrl with directed and random frames
// A per-cycle game model queues expected outputs; a negedge monitor compares them.
module tb_race_ctrl;
  localparam int LV = 3;
  localparam int CF = 10;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  race_ctrl_if bus ();

  race_ctrl #(.LIVES(LV), .CRASH_FRAMES(CF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0]  st;
    logic        pause;
    logic        rr;
    logic [1:0]  lives;
    logic [15:0] ft;
    logic        flash;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Game model: state as plain ints (0 idle,1 play,2 paused,3 crash,4 win,5 over).
  int m_st = 0, m_lives = LV, m_ft = 0, m_cnt = 0;
  bit m_hit = 0, m_fin = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input bit rst, input bit tk, input bit vo, input bit co,
                            input bit ro, input bit fl, input bit sk, input bit pk);
    bit   hev, fev, rr;
    int   ns;
    exp_t x;
    hev = vo & co & !ro;
    fev = vo & co & fl;
    rr  = 0;
    ns  = m_st;
    if (rst) begin
      m_st = 0; m_lives = LV; m_ft = 0; m_cnt = 0; m_hit = 0; m_fin = 0;
    end else begin
      if (m_st == 0) begin
        if (sk) begin ns = 1; m_ft = 0; m_lives = LV; rr = 1; end
      end else if (m_st == 1) begin
        if (tk && m_hit) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) ns = 5;
          else begin ns = 3; m_cnt = CF; end
        end else if (tk && m_fin) ns = 4;
        else if (pk) ns = 2;
        else if (tk && m_ft < 65535) m_ft = m_ft + 1;
      end else if (m_st == 2) begin
        if (pk) ns = 1;
      end else if (m_st == 3) begin
        if (tk) begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin ns = 1; rr = 1; end
        end
      end else begin
        if (sk) begin ns = 0; rr = 1; end
      end
      if (m_st == 1 && ns == 1) begin
        if (tk) begin m_hit = hev; m_fin = fev; end
        else begin m_hit = m_hit | hev; m_fin = m_fin | fev; end
      end else begin
        m_hit = 0; m_fin = 0;
      end
      m_st = ns;
    end
    x.st    = 3'(m_st);
    x.pause = (m_st != 1);
    x.rr    = rr;
    x.lives = 2'(m_lives);
    x.ft    = 16'(m_ft);
    x.flash = (m_st == 3) && m_cnt[3];
    exp_q.push_back(x);
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit vo, input bit co,
                     input bit ro, input bit fl, input bit sk, input bit pk);
    reset            = rst;
    bus.refresh_tick = tk;
    bus.video_on     = vo;
    bus.car_on       = co;
    bus.road_on      = ro;
    bus.finish_line  = fl;
    bus.start_key    = sk;
    bus.pause_key    = pk;
    model_step(rst, tk, vo, co, ro, fl, sk, pk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // One frame; positions select the cycle of an off-road pixel, finish pixel or key (-1 = none).
  task automatic frame(input int hp, input int fp, input int pk, input int sk);
    bit h, f, ev;
    for (int i = 0; i < FL; i++) begin
      h  = (i == hp);
      f  = (i == fp);
      ev = h | f;
      cyc(0, i == FL - 1, ev | 1'($urandom % 2), ev,
          ev ? !h : 1'($urandom % 2), ev ? f : 1'($urandom % 2), i == sk, i == pk);
    end
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) frame(-1, -1, -1, -1);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 16'(bus.state), 16'(e.st));
      chk("pause", 16'(bus.pause), 16'(e.pause));
      chk("road_reset", 16'(bus.road_reset), 16'(e.rr));
      chk("lives", 16'(bus.lives), 16'(e.lives));
      chk("frame_time", bus.frame_time, e.ft);
      chk("crash_flash", 16'(bus.crash_flash), 16'(e.flash));
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    // start then five clean frames
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    clean(5);
    // off-road pixel in the second frame, ride out the crash
    clean(1);
    frame(3, -1, -1, -1);
    clean(CF + 2);
    // hit and finish together, then finish alone, then restart
    frame(2, 2, -1, -1);
    clean(CF + 1);
    frame(-1, 4, -1, -1);
    clean(2);
    frame(-1, -1, -1, 1);
    idle(2);
    // three crashes end the game
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    frame(1, -1, -1, -1);
    clean(CF);
    frame(5, -1, -1, -1);
    clean(CF);
    frame(0, -1, -1, -1);
    clean(2);
    frame(-1, -1, -1, 3);
    // off-road exactly on the tick cycle counts for the next frame
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 1);
    frame(FL - 1, -1, -1, -1);
    clean(1);
    clean(CF + 1);
    // pause with injected hits, resume, pause again and reset mid-pause
    frame(-1, -1, 2, -1);
    frame(3, -1, -1, -1);
    frame(FL - 1, 1, -1, -1);
    frame(0, -1, -1, -1);
    frame(-1, -1, 1, -1);
    clean(1);
    frame(-1, -1, 3, 3);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // random play
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 700) == 0, (i % FL) == FL - 1, ($urandom % 8) != 0, ($urandom % 4) == 0,
          ($urandom % 14) != 0, ($urandom % 20) == 0, ($urandom % 12) == 0, ($urandom % 16) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
